// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU control
// codes, mux selects, FSM states and the packed control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_R    = 3'b111;
    localparam logic [2:0] ALU_ADD  = 3'b110;
    localparam logic [2:0] ALU_ORI  = 3'b101;
    localparam logic [2:0] ALU_ANDI = 3'b001;
    localparam logic [2:0] ALU_SW   = 3'b010;
    localparam logic [2:0] ALU_LW   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b000;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: op_known = 1'b1;
            default:                      op_known = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: itype_alu_op = ALU_ANDI;
            OP_ORI:  itype_alu_op = ALU_ORI;
            OP_LUI:  itype_alu_op = ALU_LUI;
            default: itype_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore decode of the control FSM state (qualified by opcode,
// jr_sel and mem_ready where a state needs them) into the datapath control word.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  opcode_i,
    input  logic        jr_sel_i,
    input  logic        mem_ready_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM_SH;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.illegal_op = !op_known(opcode_i);
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (opcode_i == OP_LW) ? ALU_LW : ALU_SW;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = M2R_MDR;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_R;
            end
            S_R_WB: begin
                // alu_op stays R so the ALU control keeps jr_sel valid here
                ctrl_o.alu_op = ALU_R;
                if (jr_sel_i) begin
                    ctrl_o.pc_write  = 1'b1;
                    ctrl_o.pc_source = PCSRC_REGA;
                end else begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dst   = REGDST_RD;
                end
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.branch_ne     = (opcode_i == OP_BNE);
            end
            S_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = itype_alu_op(opcode_i);
            end
            S_I_WB: begin
                ctrl_o.alu_op     = itype_alu_op(opcode_i);
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RA;
                ctrl_o.mem_to_reg = M2R_PC;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle MIPS control FSM: state register, next-state logic and
// reset gating of the decoded control word.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       jr_sel,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] mem_to_reg,
    output logic [1:0] reg_dst,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic [3:0] state_out,
    output logic       illegal_op
);

    state_e state_q, state_d;
    ctrl_t  ctrl, ctrl_g;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_R:                             state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default:                          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .jr_sel_i    (jr_sel),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Reset masks every strobe combinationally so an abandoned access never writes
    always_comb begin
        ctrl_g    = ctrl;
        state_out = state_q;
        if (reset) begin
            ctrl_g    = '0;
            state_out = '0;
        end
        pc_en = ctrl_g.pc_write | (ctrl_g.pc_write_cond & (zero ^ ctrl_g.branch_ne));
    end

    assign pc_write      = ctrl_g.pc_write;
    assign pc_write_cond = ctrl_g.pc_write_cond;
    assign branch_ne     = ctrl_g.branch_ne;
    assign iord          = ctrl_g.iord;
    assign mem_read      = ctrl_g.mem_read;
    assign mem_write     = ctrl_g.mem_write;
    assign ir_write      = ctrl_g.ir_write;
    assign reg_write     = ctrl_g.reg_write;
    assign alu_src_a     = ctrl_g.alu_src_a;
    assign mem_to_reg    = ctrl_g.mem_to_reg;
    assign reg_dst       = ctrl_g.reg_dst;
    assign alu_src_b     = ctrl_g.alu_src_b;
    assign pc_source     = ctrl_g.pc_source;
    assign alu_op        = ctrl_g.alu_op;
    assign illegal_op    = ctrl_g.illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle control trace; every cycle is compared at the negedge.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
        logic       branch_ne, pc_en, reg_write, alu_src_a, illegal_op;
        logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_source;
        logic [2:0] alu_op;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       jr_sel = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, pc_en, iord, mem_read, mem_write;
    logic       ir_write, reg_write, alu_src_a, illegal_op;
    logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_out;
    exp_t       dut_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int abort_cnt = -1;
    bit aborted = 0;
    logic [3:0] trace[$];
    exp_t       otrace[$];

    localparam logic [5:0] LEGAL[11] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100,
        6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b001111, 6'b100011, 6'b101011};

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .jr_sel(jr_sel), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
        .state_out(state_out), .illegal_op(illegal_op)
    );

    always_comb begin
        dut_o = '0;
        dut_o.st = state_out;            dut_o.mem_read = mem_read;
        dut_o.mem_write = mem_write;     dut_o.iord = iord;
        dut_o.ir_write = ir_write;       dut_o.pc_write = pc_write;
        dut_o.pc_write_cond = pc_write_cond; dut_o.branch_ne = branch_ne;
        dut_o.pc_en = pc_en;             dut_o.reg_write = reg_write;
        dut_o.alu_src_a = alu_src_a;     dut_o.illegal_op = illegal_op;
        dut_o.mem_to_reg = mem_to_reg;   dut_o.reg_dst = reg_dst;
        dut_o.alu_src_b = alu_src_b;     dut_o.pc_source = pc_source;
        dut_o.alu_op = alu_op;
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t blank(input int s);
        exp_t e = '0;
        e.st = 4'(s);
        return e;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        foreach (LEGAL[i]) if (LEGAL[i] == op) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // One clock cycle: drive inputs, compare every output to e at the negedge.
    task automatic step(input exp_t e_in, input logic mr, input logic [5:0] op,
                        input logic jr, input logic z);
        exp_t e = e_in;
        if (aborted) return;
        if (abort_cnt == 0) begin
            reset = 1'b1;
            aborted = 1;
            e = '0;
        end else begin
            reset = 1'b0;
            e.pc_en = e.pc_write | (e.pc_write_cond & (z ^ e.branch_ne));
        end
        if (abort_cnt >= 0) abort_cnt--;
        mem_ready = mr; opcode = op; jr_sel = jr; zero = z;
        @(negedge clk);
        trace.push_back(state_out);
        otrace.push_back(dut_o);
        total++;
        if (dut_o !== e) begin
            bad++;
            $display("FAIL cycle%0d outputs got=%h want=%h", cyc, dut_o, e);
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic reset_cycle();
        abort_cnt = 0; aborted = 0;
        step('0, rb(), 6'($urandom), rb(), rb());
        aborted = 0; abort_cnt = -1;
    endtask

    task automatic mem_wait(input exp_t e, input int w, input logic [5:0] op);
        for (int i = 0; i < w; i++) step(e, 1'b0, op, rb(), rb());
        step(e, 1'b1, op, rb(), rb());
    endtask

    task automatic exec(input logic [5:0] op, input logic jr, input logic z,
                        input int wf, input int wm);
        exp_t e;
        trace.delete(); otrace.delete();
        e = blank(0); e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 3'b110;
        for (int i = 0; i < wf; i++) step(e, 1'b0, 6'($urandom), rb(), rb());
        e.ir_write = 1; e.pc_write = 1;
        step(e, 1'b1, 6'($urandom), rb(), rb());
        e = blank(1); e.alu_src_b = 2'b11; e.alu_op = 3'b110; e.illegal_op = !legal(op);
        step(e, rb(), op, rb(), rb());
        if (!legal(op)) return;
        if (op == 6'b100011 || op == 6'b101011) begin
            e = blank(2); e.alu_src_a = 1; e.alu_src_b = 2'b10;
            e.alu_op = (op == 6'b100011) ? 3'b011 : 3'b010;
            step(e, rb(), op, rb(), rb());
            if (op == 6'b100011) begin
                e = blank(3); e.mem_read = 1; e.iord = 1;
                mem_wait(e, wm, op);
                e = blank(4); e.reg_write = 1; e.mem_to_reg = 2'b01;
                step(e, rb(), op, rb(), rb());
            end else begin
                e = blank(5); e.mem_write = 1; e.iord = 1;
                mem_wait(e, wm, op);
            end
        end else if (op == 6'b000000) begin
            e = blank(6); e.alu_src_a = 1; e.alu_op = 3'b111;
            step(e, rb(), op, rb(), rb());
            e = blank(7); e.alu_op = 3'b111;
            if (jr) begin e.pc_write = 1; e.pc_source = 2'b11; end
            else begin e.reg_write = 1; e.reg_dst = 2'b01; end
            step(e, rb(), op, jr, rb());
        end else if (op == 6'b000100 || op == 6'b000101) begin
            e = blank(8); e.alu_src_a = 1; e.pc_write_cond = 1; e.pc_source = 2'b01;
            e.branch_ne = (op == 6'b000101);
            step(e, rb(), op, rb(), z);
        end else if (op == 6'b000010 || op == 6'b000011) begin
            e = blank(op == 6'b000010 ? 11 : 12); e.pc_write = 1; e.pc_source = 2'b10;
            if (op == 6'b000011) begin e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
            step(e, rb(), op, rb(), rb());
        end else begin
            e = blank(9); e.alu_src_a = 1; e.alu_src_b = 2'b10;
            case (op)
                6'b001100: e.alu_op = 3'b001;
                6'b001101: e.alu_op = 3'b101;
                6'b001111: e.alu_op = 3'b100;
                default:   e.alu_op = 3'b110;
            endcase
            step(e, rb(), op, rb(), rb());
            e.st = 4'd10; e.alu_src_a = 0; e.alu_src_b = 2'b00;
            e.reg_write = 1;
            step(e, rb(), op, rb(), rb());
        end
    endtask

    initial begin
        #1;
        reset_cycle(); reset_cycle();

        exec(6'b000000, 0, 0, 0, 0);                     // ADD
        chk("add_len", trace.size(), 4);
        chk("add_s1", int'(trace[1]), 1); chk("add_s2", int'(trace[2]), 6);
        chk("add_s3", int'(trace[3]), 7);
        chk("add_rw", otrace[3].reg_write, 1); chk("add_rdst", otrace[3].reg_dst, 1);
        chk("add_aluop", otrace[3].alu_op, 7);

        exec(6'b100011, 0, 0, 0, 2);                     // LW, two wait states
        chk("lw_len", trace.size(), 7);
        for (int i = 3; i <= 5; i++) begin
            chk("lw_hold_st", int'(trace[i]), 3);
            chk("lw_hold_rd", otrace[i].mem_read & otrace[i].iord, 1);
        end
        chk("lw_m2r", otrace[6].mem_to_reg, 1);

        exec(6'b000100, 0, 1, 0, 0);
        chk("beq_z1_pcen", otrace[2].pc_en, 1); chk("beq_pcsrc", otrace[2].pc_source, 1);
        exec(6'b000101, 0, 1, 0, 0);
        chk("bne_z1_pcen", otrace[2].pc_en, 0);
        exec(6'b000101, 0, 0, 0, 0);
        chk("bne_z0_pcen", otrace[2].pc_en, 1);

        exec(6'b000000, 1, 0, 0, 0);                     // JR
        chk("jr_pcw", otrace[3].pc_write, 1); chk("jr_pcsrc", otrace[3].pc_source, 3);
        chk("jr_rw", otrace[3].reg_write, 0);

        exec(6'b111111, 0, 0, 0, 0);
        chk("ill_len", trace.size(), 2); chk("ill_flag", otrace[1].illegal_op, 1);
        chk("ill_writes", otrace[1].reg_write | otrace[1].mem_write | otrace[1].pc_write, 0);

        abort_cnt = 3; aborted = 0;                      // reset lands in MEM_WRITE
        exec(6'b101011, 0, 0, 0, 1);
        aborted = 0; abort_cnt = -1;
        chk("sw_rst_zero", int'(otrace[3]), 0);
        exec(6'b000010, 0, 0, 0, 0);
        chk("post_rst_st", int'(trace[0]), 0); chk("post_rst_rd", otrace[0].mem_read, 1);
        chk("post_rst_wr", otrace[0].mem_write, 0);

        exec(6'b101011, 0, 0, 0, 0); chk("cpi_sw", trace.size(), 4);
        exec(6'b001000, 0, 0, 0, 0); chk("cpi_addi", trace.size(), 4);
        exec(6'b000011, 0, 0, 0, 0); chk("cpi_jal", trace.size(), 3);
        exec(6'b100011, 0, 0, 0, 0); chk("cpi_lw", trace.size(), 5);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : LEGAL[$urandom_range(0, 10)];
            if ($urandom_range(0, 11) == 0) begin
                abort_cnt = $urandom_range(0, 6); aborted = 0;
            end
            exec(op, rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
            aborted = 0; abort_cnt = -1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle MIPS core: sequences every instruction through fetch, decode, execute, memory and write-back. Drives the shared ALU through the 3-bit `alu_op` code consumed by the ALU control unit, plus every datapath mux, register-file and memory enable. Receives `jr_sel` back from the ALU control and `zero` from the ALU. Waits on a `mem_ready` handshake for every memory access.

## Interface
- No parameters; all encodings are fixed in `mips_ctrl_pkg`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  `IR[31:26]`; valid from DECODE onward.
- `jr_sel`  in  1  from ALU control; high when the funct field is JR (`alu_op`=111, funct=001000).
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `branch_ne`, `pc_en`  out  1 each
  - `pc_en = pc_write | (pc_write_cond & (zero ^ branch_ne))`.
- `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_write`, `alu_src_a`  out  1 each.
- `mem_to_reg`, `reg_dst`, `alu_src_b`, `pc_source`  out  2 each.
- `alu_op`  out  3  ALU control code.
- `state_out`  out  4  current state, for debug.
- `illegal_op`  out  1  unknown opcode seen in DECODE.

## Operation
- **Mux select encodings**
  - `alu_src_b`: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
  - `reg_dst`: 00 = rt, 01 = rd, 10 = $31.
  - `mem_to_reg`: 00 = ALUOut, 01 = MDR, 10 = PC.
  - `pc_source`: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register A.
- **`alu_op` codes:** R=111, ADDI/add=110, ORI=101, ANDI=001, SW=010, LW=011, LUI=100, branch/sub=000.
- **Opcodes:** R 000000, J 000010, JAL 000011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, LUI 001111, LW 100011, SW 101011.
- **Output rule:** Moore outputs decoded from state. Any output not listed for a state is 0.
- **States** (encoding, asserted outputs, next state):
  - FETCH(0): `mem_read`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=110, `pc_source`=00. `ir_write` and `pc_write` only when `mem_ready`. Stay while `!mem_ready`, else DECODE.
  - DECODE(1): `alu_src_b`=11, `alu_op`=110 (branch target into ALUOut).
    - LW/SW → MEM_ADDR; R → R_EXEC; BEQ/BNE → BRANCH; ADDI/ANDI/ORI/LUI → I_EXEC; J → JUMP; JAL → JAL.
    - Any other opcode: `illegal_op`=1, → FETCH.
  - MEM_ADDR(2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=011 (LW) or 010 (SW). → MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ(3): `mem_read`, `iord`=1. Wait for `mem_ready`, then → MEM_WB.
  - MEM_WB(4): `reg_write`, `reg_dst`=00, `mem_to_reg`=01. → FETCH.
  - MEM_WRITE(5): `mem_write`, `iord`=1. Wait for `mem_ready`, then → FETCH.
  - R_EXEC(6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111. → R_WB.
  - R_WB(7): `alu_op`=111 held so `jr_sel` stays valid. → FETCH.
    - `jr_sel`=0: `reg_write`, `reg_dst`=01.
    - `jr_sel`=1: `pc_write`, `pc_source`=11, no `reg_write`.
  - BRANCH(8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=000, `pc_write_cond`, `pc_source`=01, `branch_ne`=(opcode==BNE). → FETCH.
  - I_EXEC(9): `alu_src_a`=1, `alu_src_b`=10, `alu_op` per opcode (ADDI 110, ANDI 001, ORI 101, LUI 100). → I_WB.
  - I_WB(10): same `alu_op` held, `reg_write`, `reg_dst`=00, `mem_to_reg`=00. → FETCH.
  - JUMP(11): `pc_write`, `pc_source`=10. → FETCH.
  - JAL(12): `pc_write`, `pc_source`=10, `reg_write`, `reg_dst`=10, `mem_to_reg`=10 (PC already holds PC+4). → FETCH.
- **Unused encodings 13–15:** → FETCH, all outputs 0.

## Timing
- **Reset:**
  - While `reset`=1, every output is forced to 0 (including `state_out`), so no memory or register write can occur.
  - The state register loads FETCH; the first fetch happens in the first cycle after `reset` falls.
  - Reset mid-instruction abandons it; pending writes never happen.
- **CPI with `mem_ready` tied to 1:** R 4, LW 5, SW 4, I-type 4, BEQ/BNE 3, J/JAL 3.
- **Memory wait states:** each low-`mem_ready` cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Strobes stay high and stable throughout.
- **Same-cycle completion:** `mem_ready` high in the same cycle the strobe first rises completes the access that cycle.
- **`pc_en`:** combinational in `zero`. Valid only in BRANCH for conditional updates.

## Structure
- **`mips_ctrl_pkg`:**
  - opcode constants;
  - `alu_op` codes (shared with the ALU control unit);
  - state enumeration;
  - all mux-select encodings.
- **Sub-module `mc_output_decode`:** purely combinational state/opcode/`jr_sel`/`mem_ready` → control word.
- **Top:** holds the state register, next-state logic and reset gating.

## Test plan
- **ADD:** reset, then opcode=000000, `jr_sel`=0, `mem_ready`=1 → `state_out` 0,1,6,7,0. In R_WB: `reg_write`=1, `reg_dst`=01, `alu_op`=111.
- **LW with wait states:** `mem_ready` low for 2 cycles in MEM_READ → state 3 held 3 cycles with `mem_read`=1, `iord`=1. Total 7 cycles; MEM_WB `mem_to_reg`=01.
- **Branches:**
  - BEQ, `zero`=1 → `pc_en`=1, `pc_source`=01.
  - BNE, `zero`=1 → `pc_en`=0.
  - BNE, `zero`=0 → `pc_en`=1.
- **JR:** opcode 000000, `jr_sel`=1 → R_WB `pc_write`=1, `pc_source`=11, `reg_write`=0.
- **Illegal opcode:** 111111 → `illegal_op`=1 for one cycle in DECODE, then FETCH, no write strobes.
- **Reset mid-store:** `reset` asserted in MEM_WRITE → all outputs 0 that cycle. First cycle after release: state 0, `mem_read`=1, `mem_write`=0.
